// File: rtl/digital_lock_sysid_reader_if.sv
// Avalon-MM read-only link between the sysid reader (master) and the
// system-ID slave.
interface digital_lock_sysid_reader_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/digital_lock_sysid_reader.sv
// Boot-time image check: reads the system-ID word (and optionally the timestamp)
// over Avalon-MM and reports match / mismatch / timeout to the lock controller.
module digital_lock_sysid_reader #(
   parameter logic [31:0] EXPECTED_ID    = 32'd1769038348,
   parameter logic [31:0] EXPECTED_TS    = 32'd0,
   parameter bit          CHECK_TS       = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   digital_lock_sysid_reader_if.master       avm,
   output logic                              busy,
   output logic                              done,
   output logic                              match,
   output logic                              timeout,
   output logic [31:0]                       id_value,
   output logic [31:0]                       ts_value
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_FIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;
   logic            r_match;
   logic            r_timeout;
   logic [31:0]     r_id;
   logic [31:0]     r_ts;

   logic            w_go;
   logic            w_expire;
   logic            w_cap_id;
   logic            w_cap_ts;
   logic            w_to;
   logic            w_cnt_clr;
   logic            w_read;
   logic            w_addr;
   logic            w_in_xfer;

   // busy stays high through the done cycle, so a start there is dropped too
   assign w_go      = (r_state == S_IDLE) && start && !r_busy;
   assign w_expire  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_in_xfer = (r_state == S_ID_REQ) || (r_state == S_ID_WAIT) ||
                      (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_cap_id  = 1'b0;
      w_cap_ts  = 1'b0;
      w_to      = 1'b0;
      w_cnt_clr = 1'b0;
      w_read    = 1'b0;
      w_addr    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_next    = S_ID_REQ;
               w_cnt_clr = 1'b1;
            end
         end
         S_ID_REQ: begin
            w_read = 1'b1;
            // zero-latency slave: data can arrive in the accept cycle itself
            if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
               w_cap_id  = 1'b1;
               w_next    = CHECK_TS ? S_TS_REQ : S_FIN;
               w_cnt_clr = CHECK_TS;
            end else if (w_expire) begin
               w_to   = 1'b1;
               w_next = S_FIN;
            end else if (!avm.avm_waitrequest) begin
               w_next = S_ID_WAIT;
            end
         end
         S_ID_WAIT: begin
            if (avm.avm_readdatavalid) begin
               w_cap_id  = 1'b1;
               w_next    = CHECK_TS ? S_TS_REQ : S_FIN;
               w_cnt_clr = CHECK_TS;
            end else if (w_expire) begin
               w_to   = 1'b1;
               w_next = S_FIN;
            end
         end
         S_TS_REQ: begin
            w_read = 1'b1;
            w_addr = 1'b0;
            if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
               w_cap_ts = 1'b1;
               w_next   = S_FIN;
            end else if (w_expire) begin
               w_to   = 1'b1;
               w_next = S_FIN;
            end else if (!avm.avm_waitrequest) begin
               w_next = S_TS_WAIT;
            end
         end
         S_TS_WAIT: begin
            if (avm.avm_readdatavalid) begin
               w_cap_ts = 1'b1;
               w_next   = S_FIN;
            end else if (w_expire) begin
               w_to   = 1'b1;
               w_next = S_FIN;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_match   <= 1'b0;
         r_timeout <= 1'b0;
         r_id      <= '0;
         r_ts      <= '0;
      end else begin
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_in_xfer) r_cnt <= r_cnt + 1'b1;

         if (w_go)        r_busy <= 1'b1;
         else if (r_done) r_busy <= 1'b0;

         r_done <= (r_state == S_FIN);

         if (w_go) begin
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
         end else if (w_to) begin
            r_timeout <= 1'b1;
         end

         if (w_cap_id) r_id <= avm.avm_readdata;
         if (w_cap_ts) r_ts <= avm.avm_readdata;

         if (r_state == S_FIN)
            r_match <= (r_id == EXPECTED_ID) &&
                       (!CHECK_TS || (r_ts == EXPECTED_TS)) && !r_timeout;
      end
   end

   assign avm.avm_read    = w_read;
   assign avm.avm_address = w_addr;
   assign busy            = r_busy;
   assign done            = r_done;
   assign match           = r_match;
   assign timeout         = r_timeout;
   assign id_value        = r_id;
   assign ts_value        = r_ts;

endmodule

// File: tb/tb_digital_lock_sysid_reader.sv
// Bench for digital_lock_sysid_reader: two instances (with and without the
// timestamp read) driven by a configurable Avalon slave and a transaction-level model.
module tb_digital_lock_sysid_reader;

   localparam logic [31:0] GOOD = 32'd1769038348;
   localparam int          TO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   logic [1:0]  busy_o, done_o, match_o, to_o;
   logic [1:0][31:0] id_o, ts_o;
   logic [1:0]  rd_o, addr_o;
   logic [1:0]  s_wr, s_rdv;
   logic [1:0][31:0] s_rdata;

   digital_lock_sysid_reader_if ifa ();
   digital_lock_sysid_reader_if ifb ();

   assign ifa.avm_waitrequest   = s_wr[0];
   assign ifa.avm_readdatavalid = s_rdv[0];
   assign ifa.avm_readdata      = s_rdata[0];
   assign ifb.avm_waitrequest   = s_wr[1];
   assign ifb.avm_readdatavalid = s_rdv[1];
   assign ifb.avm_readdata      = s_rdata[1];
   assign rd_o[0]   = ifa.avm_read;
   assign addr_o[0] = ifa.avm_address;
   assign rd_o[1]   = ifb.avm_read;
   assign addr_o[1] = ifb.avm_address;

   digital_lock_sysid_reader #(.CHECK_TS(1'b1), .TIMEOUT_CYCLES(TO)) u_a (
      .clock(clk), .reset(rst), .start(start[0]), .avm(ifa),
      .busy(busy_o[0]), .done(done_o[0]), .match(match_o[0]), .timeout(to_o[0]),
      .id_value(id_o[0]), .ts_value(ts_o[0]));

   digital_lock_sysid_reader #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(TO)) u_b (
      .clock(clk), .reset(rst), .start(start[1]), .avm(ifb),
      .busy(busy_o[1]), .done(done_o[1]), .match(match_o[1]), .timeout(to_o[1]),
      .id_value(id_o[1]), .ts_value(ts_o[1]));

   always #5 clk = ~clk;

   // slave configuration, indexed [instance][address]
   int          cw [2][2];
   int          cd [2][2];
   bit          csil [2][2];
   logic [31:0] cdat [2][2];
   int          hcnt [2];
   int          pcnt [2];
   bit          pend [2];
   int          paddr [2];
   int          nreads [2];
   int          hi_cnt [2][2];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_id [2];
   logic [31:0] m_ts [2];

   // slave: waitrequest for cw cycles, readdatavalid cd cycles after accept
   initial begin
      s_wr = '0; s_rdv = '0; s_rdata = '0;
      for (int u = 0; u < 2; u++) begin
         hcnt[u] = 0; pcnt[u] = 0; pend[u] = 0; paddr[u] = 1; nreads[u] = 0;
         for (int a = 0; a < 2; a++) begin
            cw[u][a] = 0; cd[u][a] = 1; csil[u][a] = 0; cdat[u][a] = '0; hi_cnt[u][a] = 0;
         end
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            s_rdv[u] = 1'b0;
            s_wr[u]  = 1'b0;
            if (pend[u]) begin
               pcnt[u]++;
               if (pcnt[u] >= cd[u][paddr[u]]) begin
                  pend[u] = 0;
                  if (!csil[u][paddr[u]]) begin
                     s_rdv[u]   = 1'b1;
                     s_rdata[u] = cdat[u][paddr[u]];
                  end
               end
            end
            if (rst) begin
               hcnt[u] = 0;
            end else if (rd_o[u]) begin
               int a;
               a = int'(addr_o[u]);
               hi_cnt[u][a]++;
               if (hcnt[u] < cw[u][a]) begin
                  s_wr[u] = 1'b1;
                  hcnt[u]++;
               end else begin
                  hcnt[u] = 0;
                  nreads[u]++;
                  if (cd[u][a] == 0) begin
                     if (!csil[u][a]) begin
                        s_rdv[u]   = 1'b1;
                        s_rdata[u] = cdat[u][a];
                     end
                  end else begin
                     pend[u] = 1; pcnt[u] = 0; paddr[u] = a;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Each read occupies (wait + 1 + latency) cycles or TO cycles when it times out;
   // done follows FIN, two cycles after the last read cycle.
   function automatic void model(input bit cts, input int wi, di, wt, dt,
                                 input bit si, st, input logic [31:0] vi, vt,
                                 inout logic [31:0] mid, mts,
                                 output bit mm, mto, output int mlat, mreads, mhi1, mhi0);
      int t, sum;
      sum = 0; mto = 0; mreads = 1; mhi1 = wi + 1; mhi0 = 0;
      t = si ? TO + 1 : wi + 1 + di;
      if (t <= TO) begin sum += t; mid = vi; end
      else begin sum += TO; mto = 1; end
      if (cts && !mto) begin
         mreads = 2; mhi0 = wt + 1;
         t = st ? TO + 1 : wt + 1 + dt;
         if (t <= TO) begin sum += t; mts = vt; end
         else begin sum += TO; mto = 1; end
      end
      mm   = !mto && (mid == GOOD) && (!cts || mts == 32'd0);
      mlat = sum + 2;
   endfunction

   task automatic run(input int u, input int wi, di, wt, dt, input bit si, st,
                      input logic [31:0] vi, vt, output int lat);
      cw[u][1] = wi; cd[u][1] = di; csil[u][1] = si; cdat[u][1] = vi;
      cw[u][0] = wt; cd[u][0] = dt; csil[u][0] = st; cdat[u][0] = vt;
      nreads[u] = 0; hi_cnt[u][0] = 0; hi_cnt[u][1] = 0;
      @(negedge clk);
      start[u] = 1'b1;
      @(posedge clk); #1;
      start[u] = 1'b0;
      lat = 1;
      while (!done_o[u] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // run one sequence and compare every observable against the model
   task automatic exercise(input string nm, input int u, input int wi, di, wt, dt,
                           input bit si, st, input logic [31:0] vi, vt);
      int lat, mlat, mreads, mhi1, mhi0;
      bit mm, mto;
      run(u, wi, di, wt, dt, si, st, vi, vt, lat);
      model(u == 0, wi, di, wt, dt, si, st, vi, vt, m_id[u], m_ts[u],
            mm, mto, mlat, mreads, mhi1, mhi0);
      chk({nm, " latency"}, lat, mlat);
      chk({nm, " match"},   match_o[u], mm);
      chk({nm, " timeout"}, to_o[u], mto);
      chk({nm, " id"},      id_o[u], m_id[u]);
      chk({nm, " ts"},      ts_o[u], m_ts[u]);
      chk({nm, " reads"},   nreads[u], mreads);
      chk({nm, " id_rd_cycles"}, hi_cnt[u][1], mhi1);
      chk({nm, " ts_rd_cycles"}, hi_cnt[u][0], mhi0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          w_id, d_id, w_ts, d_ts;
      bit          sil_id;
      logic [31:0] did, dts;
      bit          e_match, e_to;
      int          e_lat, e_reads;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat;
      vecs[0] = '{0, 1, 0, 1, 0, GOOD,  32'd0, 1, 0, 6,  2};
      vecs[1] = '{3, 1, 0, 1, 0, GOOD,  32'd0, 1, 0, 9,  2};
      vecs[2] = '{0, 1, 0, 1, 0, 32'd1, 32'd0, 0, 0, 6,  2};
      vecs[3] = '{0, 1, 0, 1, 1, GOOD,  32'd0, 0, 1, 10, 1};
      vecs[4] = '{0, 0, 0, 0, 0, GOOD,  32'd0, 1, 0, 4,  2};
      vecs[5] = '{0, 1, 0, 1, 0, GOOD,  32'd5, 0, 0, 6,  2};
      vecs[6] = '{3, 4, 0, 1, 0, GOOD,  32'd0, 1, 0, 12, 2};
      vecs[7] = '{4, 4, 0, 1, 0, GOOD,  32'd0, 0, 1, 10, 1};
      m_id[0] = '0; m_ts[0] = '0; m_id[1] = '0; m_ts[1] = '0;

      start = '0;
      rst   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",    busy_o[0], 1'b0);
      chk("reset done",    done_o[0], 1'b0);
      chk("reset match",   match_o[0], 1'b0);
      chk("reset timeout", to_o[0], 1'b0);
      chk("reset id",      id_o[0], 32'd0);
      chk("reset ts",      ts_o[0], 32'd0);
      chk("reset read",    rd_o[0], 1'b0);
      chk("reset address", addr_o[0], 1'b1);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         int mlat, mreads, mhi1, mhi0;
         bit mm, mto;
         run(0, vecs[i].w_id, vecs[i].d_id, vecs[i].w_ts, vecs[i].d_ts, vecs[i].sil_id,
             1'b0, vecs[i].did, vecs[i].dts, lat);
         model(1'b1, vecs[i].w_id, vecs[i].d_id, vecs[i].w_ts, vecs[i].d_ts, vecs[i].sil_id,
               1'b0, vecs[i].did, vecs[i].dts, m_id[0], m_ts[0], mm, mto, mlat, mreads, mhi1, mhi0);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].e_lat);
         chk($sformatf("vec%0d busy_at_done", i), busy_o[0], 1'b1);
         chk($sformatf("vec%0d match", i), match_o[0], vecs[i].e_match);
         chk($sformatf("vec%0d timeout", i), to_o[0], vecs[i].e_to);
         chk($sformatf("vec%0d reads", i), nreads[0], vecs[i].e_reads);
         chk($sformatf("vec%0d id", i), id_o[0], m_id[0]);
         chk($sformatf("vec%0d ts", i), ts_o[0], m_ts[0]);
         chk($sformatf("vec%0d id_rd_cycles", i), hi_cnt[0][1], vecs[i].w_id + 1);
         chk($sformatf("vec%0d ts_rd_cycles", i), hi_cnt[0][0],
             (vecs[i].e_reads == 2) ? vecs[i].w_ts + 1 : 0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d busy_after", i), busy_o[0], 1'b0);
         chk($sformatf("vec%0d done_pulse", i), done_o[0], 1'b0);
         @(posedge clk); #1;
      end

      // ID-only instance
      exercise("idonly_good", 1, 0, 1, 0, 1, 1'b0, 1'b0, GOOD, 32'd7);
      exercise("idonly_bad",  1, 2, 0, 0, 1, 1'b0, 1'b0, 32'd3, 32'd0);
      exercise("idonly_to",   1, 0, 1, 0, 1, 1'b1, 1'b0, GOOD, 32'd0);

      // start while busy (mid-run, FIN cycle, done cycle) is dropped
      cw[0][1] = 0; cd[0][1] = 1; csil[0][1] = 0; cdat[0][1] = GOOD;
      cw[0][0] = 0; cd[0][0] = 1; csil[0][0] = 0; cdat[0][0] = 32'd0;
      nreads[0] = 0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (int l = 2; l <= 6; l++) begin
         @(posedge clk); #1;
         start[0] = (l == 2) || (l == 5) || (l == 6);
      end
      chk("busy_start done", done_o[0], 1'b1);
      chk("busy_start busy", busy_o[0], 1'b1);
      chk("busy_start match", match_o[0], 1'b1);
      @(posedge clk); #1;
      start[0] = 1'b0;
      chk("busy_start busy_low", busy_o[0], 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_start reads", nreads[0], 32'd2);
      chk("busy_start idle", busy_o[0], 1'b0);
      m_id[0] = GOOD; m_ts[0] = 32'd0;

      // reset while waiting for ID data; the late response must not land
      cd[0][1] = 3;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid busy", busy_o[0], 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid busy0",  busy_o[0], 1'b0);
      chk("rst_mid match",  match_o[0], 1'b0);
      chk("rst_mid id",     id_o[0], 32'd0);
      chk("rst_mid read",   rd_o[0], 1'b0);
      begin
         int seen_done;
         seen_done = 0;
         repeat (6) begin
            @(posedge clk); #1;
            if (done_o[0]) seen_done++;
         end
         chk("rst_mid stray_done", seen_done, 32'd0);
      end
      chk("rst_mid stray_id", id_o[0], 32'd0);
      chk("rst_mid timeout",  to_o[0], 1'b0);
      m_id[0] = '0; m_ts[0] = '0; m_id[1] = '0; m_ts[1] = '0;

      // randomized sequences against the model
      for (int i = 0; i < 40; i++) begin
         int u;
         logic [31:0] vi, vt;
         u  = (i % 4 == 3) ? 1 : 0;
         vi = ($urandom_range(0, 2) != 0) ? GOOD : $urandom;
         vt = ($urandom_range(0, 2) != 0) ? 32'd0 : $urandom;
         exercise($sformatf("rand%0d", i), u,
                  $urandom_range(0, 5), $urandom_range(0, 4),
                  $urandom_range(0, 5), $urandom_range(0, 4),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), vi, vt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
